// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: shift-and-add-3 binary-to-BCD converter feeding a
// multiplexed seven-segment scanner with leading-zero blanking,
// overflow dashes and per-digit decimal points.
module ssd_scan_ctrl #(
  parameter int BIN_W   = 10,
  parameter int NDIG    = 4,
  parameter int DIV_END = 50000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BIN_W-1:0]    DIN,
  input  logic                LOAD,
  input  logic                BLANK_LZ,
  input  logic [NDIG-1:0]     DP_EN,
  output logic                BUSY,
  output logic                VALID,
  output logic                OVF,
  output logic [4*NDIG-1:0]   BCD,
  output logic [NDIG-1:0]     AN,
  output logic [7:0]          SEG
);

  // Converter BCD field sized generously so any BIN_W value converts exactly,
  // and never narrower than the displayed digits.
  localparam int SRBITS   = (BIN_W * 121 + 99) / 100 + 4;
  localparam int CONVDIG0 = (SRBITS + 3) / 4;
  localparam int CONVDIG  = (CONVDIG0 > NDIG) ? CONVDIG0 : NDIG;
  localparam int CW       = 4 * CONVDIG;
  localparam int CNTW     = $clog2(BIN_W + 1);
  localparam int DIVW     = $clog2(DIV_END + 1);
  localparam int IW       = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} convState_t;

  convState_t       state;
  logic [CW-1:0]    bcdReg;
  logic [CW-1:0]    bcdAdj;
  logic [BIN_W-1:0] binReg;
  logic [CNTW-1:0]  shiftCnt;
  logic             ovfNext;

  logic [DIVW-1:0]  divCnt;
  logic             tick;
  logic [IW-1:0]    scanIdx;

  logic             seen;
  logic [NDIG-1:0]  blankMask;
  logic [3:0]       curNib;
  logic             curBlank;
  logic             curDp;
  logic [6:0]       curSeg;

  function automatic logic [6:0] digitSeg(input logic [3:0] nib);
    case (nib)
      4'd0:    digitSeg = 7'h40;
      4'd1:    digitSeg = 7'h79;
      4'd2:    digitSeg = 7'h24;
      4'd3:    digitSeg = 7'h30;
      4'd4:    digitSeg = 7'h19;
      4'd5:    digitSeg = 7'h12;
      4'd6:    digitSeg = 7'h02;
      4'd7:    digitSeg = 7'h78;
      4'd8:    digitSeg = 7'h00;
      4'd9:    digitSeg = 7'h10;
      default: digitSeg = 7'h7F;
    endcase
  endfunction

  assign BUSY = (state != IDLE);
  assign tick = (divCnt == DIVW'(DIV_END));

  // Add-3 correction applied to every nibble of 5 or more before each shift.
  always_comb begin
    bcdAdj = bcdReg;
    for (int d = 0; d < CONVDIG; d++) begin
      if (bcdReg[4*d +: 4] >= 4'd5) bcdAdj[4*d +: 4] = bcdReg[4*d +: 4] + 4'd3;
    end
  end

  // Any nonzero digit beyond the displayed ones means the value cannot be shown.
  always_comb begin
    ovfNext = 1'b0;
    for (int d = NDIG; d < CONVDIG; d++) begin
      if (bcdReg[4*d +: 4] != 4'd0) ovfNext = 1'b1;
    end
  end

  // Conversion FSM: capture, BIN_W shift steps, then publish result for one DONE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bcdReg   <= '0;
      binReg   <= '0;
      shiftCnt <= '0;
      BCD      <= '0;
      OVF      <= 1'b0;
      VALID    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (LOAD) begin
            binReg   <= DIN;
            bcdReg   <= '0;
            shiftCnt <= CNTW'(BIN_W);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcdReg, binReg} <= {bcdAdj, binReg} << 1;
          shiftCnt         <= shiftCnt - CNTW'(1);
          if (shiftCnt == CNTW'(1)) state <= DONE;
        end
        DONE: begin
          OVF   <= ovfNext;
          BCD   <= ovfNext ? {NDIG{4'h9}} : bcdReg[4*NDIG-1:0];
          VALID <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh divider and scan index; the index steps once per divider wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      divCnt  <= '0;
      scanIdx <= '0;
    end else begin
      divCnt <= tick ? '0 : divCnt + DIVW'(1);
      if (tick) scanIdx <= (scanIdx == IW'(NDIG - 1)) ? '0 : scanIdx + IW'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    seen      = 1'b0;
    blankMask = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (BCD[4*i +: 4] != 4'd0) seen = 1'b1;
      blankMask[i] = ~seen && (i != 0);
    end
  end

  // Pick the scanned digit and choose its glyph: dash on overflow, blank, or decoded value.
  always_comb begin
    curNib   = 4'd0;
    curBlank = 1'b0;
    curDp    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (scanIdx == IW'(i)) begin
        curNib   = BCD[4*i +: 4];
        curBlank = blankMask[i];
        curDp    = DP_EN[i];
      end
    end
    if (OVF)                      curSeg = 7'h3F;
    else if (BLANK_LZ && curBlank) curSeg = 7'h7F;
    else                          curSeg = digitSeg(curNib);
  end

  // Registered display drive so anode and cathode change together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      AN  <= '1;
      SEG <= 8'hFF;
    end else begin
      AN  <= ~(NDIG'(1) << scanIdx);
      SEG <= {~curDp, curSeg};
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl with a decimal
// arithmetic reference model and randomized conversion requests.
module tb_ssd_scan_ctrl;

  localparam int BW    = 14;
  localparam int ND    = 4;
  localparam int DE    = 3;
  localparam int LIMIT = 10**ND - 1;

  localparam logic [6:0] SEGTBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int            due;
    logic [4*ND-1:0] bcd;
    logic          ovf;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [BW-1:0]   din;
  logic            load;
  logic            blankLz;
  logic [ND-1:0]   dpEn;
  logic            busy;
  logic            valid;
  logic            ovf;
  logic [4*ND-1:0] bcd;
  logic [ND-1:0]   an;
  logic [7:0]      seg;

  int checks = 0;
  int fails  = 0;

  // reference model state
  int              edgeNo = 0;
  int              nEdge = 0;
  int              scanPos;
  bit              curPending = 0;
  bit              accept;
  int              curDue;
  logic [4*ND-1:0] curBcd;
  logic            curOvf;
  logic [4*ND-1:0] dispBcd = '0;
  logic            dispOvf = 1'b0;
  logic [ND-1:0]   expAn = '1;
  logic [7:0]      expSeg = 8'hFF;
  logic            expBusy = 1'b0;
  exp_t            sbQ[$];
  exp_t            popped;
  bit              validDue;

  ssd_scan_ctrl #(.BIN_W(BW), .NDIG(ND), .DIV_END(DE)) dut (
    .CLK(clk), .RST(rst), .DIN(din), .LOAD(load), .BLANK_LZ(blankLz),
    .DP_EN(dpEn), .BUSY(busy), .VALID(valid), .OVF(ovf), .BCD(bcd),
    .AN(an), .SEG(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] toBcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = (v > LIMIT) ? 4'h9 : 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] segModel(input int idx, input logic [4*ND-1:0] b,
                                          input logic o, input logic bl, input logic [ND-1:0] dp);
    logic [3:0] nib;
    logic [6:0] s;
    nib = b[4*idx +: 4];
    if (o)                                   s = 7'h3F;
    else if (bl && idx > 0 && (b >> (4*idx)) == '0) s = 7'h7F;
    else if (nib > 4'd9)                     s = 7'h7F;
    else                                     s = SEGTBL[nib];
    return {~dp[idx], s};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, edgeNo, act, expv);
    end
  endtask

  task automatic applyStimulus(input int value);
    din  = BW'(value);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (curPending && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Reference model: decimal arithmetic for results, edge counting for the scan.
  initial forever begin
    @(posedge clk);
    edgeNo++;
    if (rst) begin
      nEdge      = 0;
      curPending = 0;
      sbQ.delete();
      dispBcd    = '0;
      dispOvf    = 1'b0;
      expAn      = '1;
      expSeg     = 8'hFF;
      expBusy    = 1'b0;
    end else begin
      nEdge++;
      scanPos = ((nEdge - 1) / (DE + 1)) % ND;
      expAn   = ~(ND'(1) << scanPos);
      expSeg  = segModel(scanPos, dispBcd, dispOvf, blankLz, dpEn);
      accept  = load && !curPending;
      if (curPending && edgeNo == curDue) begin
        dispBcd    = curBcd;
        dispOvf    = curOvf;
        curPending = 0;
      end
      if (accept) begin
        curOvf     = (int'(din) > LIMIT);
        curBcd     = toBcd(int'(din));
        curDue     = edgeNo + BW + 1;
        curPending = 1;
        sbQ.push_back('{curDue, curBcd, curOvf});
      end
      expBusy = curPending;
    end
  end

  // Monitor: compares held outputs every cycle and pops the scoreboard on VALID.
  initial forever begin
    @(negedge clk);
    if (edgeNo > 0) begin
      checkOutput("busy", 64'(busy), 64'(expBusy));
      checkOutput("an", 64'(an), 64'(expAn));
      checkOutput("seg", 64'(seg), 64'(expSeg));
      checkOutput("bcd_hold", 64'(bcd), 64'(dispBcd));
      checkOutput("ovf_hold", 64'(ovf), 64'(dispOvf));
      validDue = (sbQ.size() > 0) && (sbQ[0].due == edgeNo);
      if (valid || validDue) begin
        checkOutput("valid", 64'(valid), 64'(validDue));
        if (validDue) begin
          popped = sbQ.pop_front();
          checkOutput("result_bcd", 64'(bcd), 64'(popped.bcd));
          checkOutput("result_ovf", 64'(ovf), 64'(popped.ovf));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v;
    rst = 1'b1; load = 1'b0; din = '0; blankLz = 1'b0; dpEn = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] basic conversion 987");
    applyStimulus(987);
    waitIdle();
    idleCycles(4);

    $display("[TB] blanking and decimal point, value 7");
    blankLz = 1'b1; dpEn = 4'b0100;
    applyStimulus(7);
    waitIdle();
    idleCycles(20);

    $display("[TB] overflow and boundary values");
    blankLz = 1'b0; dpEn = '0;
    foreach (SEGTBL[i]) begin end
    applyStimulus(12345); waitIdle(); idleCycles(16);
    applyStimulus(LIMIT); waitIdle(); idleCycles(4);
    applyStimulus(LIMIT + 1); waitIdle(); idleCycles(16);
    blankLz = 1'b1;
    applyStimulus(0); waitIdle(); idleCycles(16);
    applyStimulus((1 << BW) - 1); waitIdle(); idleCycles(4);

    $display("[TB] load during busy is ignored");
    blankLz = 1'b0;
    applyStimulus(987);
    idleCycles(2);
    applyStimulus(555);
    waitIdle();
    idleCycles(4);

    $display("[TB] load accepted in the VALID cycle");
    applyStimulus(1234);
    waitIdle();
    applyStimulus(4321);
    waitIdle();
    idleCycles(3);

    $display("[TB] reset in the middle of a conversion");
    applyStimulus(4321);
    idleCycles(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycles(30);

    $display("[TB] randomized requests");
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) blankLz = 1'($urandom_range(0, 1));
      dpEn = ND'($urandom);
      case ($urandom_range(0, 5))
        0:       v = LIMIT;
        1:       v = LIMIT + 1;
        2:       v = $urandom_range(0, 9);
        default: v = $urandom_range(0, (1 << BW) - 1);
      endcase
      applyStimulus(v);
      idleCycles($urandom_range(0, 20));
    end
    waitIdle();
    idleCycles(8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
